step_feeder: RTL and testbench

STEP_FEEDER -- requirements
Module: step_feeder

---
 rtl/step_feeder_if.sv | 23 ++
 rtl/step_feeder.sv | 216 +++++++++++++++++++++
 tb/tb_step_feeder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_feeder_if.sv
// Load-side handshake bundle for step_feeder.
// The host (master) offers {load_steps, load_word} with load_valid, and the
// feeder (slave) reports load_ready when its buffer has room.
interface step_feeder_if;
  logic       load_valid;
  logic [9:0] load_word;
  logic [1:0] load_steps;
  logic       load_ready;

  modport master (
    output load_valid,
    output load_word,
    output load_steps,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_word,
    input  load_steps,
    output load_ready
  );
endinterface : step_feeder_if

// File: rtl/step_feeder.sv
// step_feeder: buffers switch words and their clock-step counts, then issues each
// entry to a hand-clocked processor. For every entry the word is held on
// raw_data_out while clock_button_out produces (steps+1) active-low pulses,
// each PULSE_CYCLES cycles low followed by PULSE_CYCLES cycles high.
//
// Optional feature, macro STEP_FEEDER_DONE_SYNC_EN: done_in is brought in
// through a 2-flop synchronizer. After an entry whose word has bits [9:8]==0
// and bits [3:0]!=0, the feeder holds in WAIT_DONE until the synchronized
// done_in is seen high. Without the macro, done_in is ignored and WAIT_DONE
// is never entered.
module step_feeder #(
  parameter int DEPTH        = 16,
  parameter int PULSE_CYCLES = 8
) (
  input  logic                   clock_50mhz,
  input  logic                   reset_n,
  step_feeder_if.slave           load,
  input  logic                   run,
  input  logic                   done_in,
  output logic [9:0]             raw_data_out,
  output logic                   clock_button_out,
  output logic                   busy,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [PW-1:0] PHASE_LOAD = PW'(PULSE_CYCLES - 1);

  typedef struct packed {
    logic [1:0] steps;
    logic [9:0] word;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOW       = 2'd1,
    HIGH      = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Buffer storage and occupancy
  // ---------------------------------------------------------------------------
  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  entry_t          head;
  logic            push;
  logic            pop;

  // ---------------------------------------------------------------------------
  // Issue FSM state
  // ---------------------------------------------------------------------------
  state_t          state_q,     state_d;
  logic [PW-1:0]   phase_q,     phase_d;
  logic [1:0]      remaining_q, remaining_d;
  logic [9:0]      raw_q,       raw_d;
  logic            button_q;
  logic            done_sync;
  logic            wait_needed;

  assign head  = mem[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  assign load.load_ready = ~full;

  // A full buffer still accepts an entry on the edge where the head is popped,
  // so a streaming host never loses a slot while the feeder drains.
  assign push = load.load_valid & (~full | pop);

`ifdef STEP_FEEDER_DONE_SYNC_EN
  logic done_meta_q;
  logic done_sync_q;

  // Two-flop synchronizer for the processor's asynchronous done indicator.
  always_ff @(posedge clock_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      done_meta_q <= 1'b0;
      done_sync_q <= 1'b0;
    end else begin
      done_meta_q <= done_in;
      done_sync_q <= done_meta_q;
    end
  end

  assign done_sync   = done_sync_q;
  // Only instructions with these opcode/operand bits report completion on done_in.
  assign wait_needed = (raw_q[9:8] == 2'b00) && (raw_q[3:0] != 4'b0000);
`else
  logic unused_done_in;

  assign unused_done_in = done_in;
  // WAIT_DONE is unreachable here; a set done_sync makes it fall straight to IDLE anyway.
  assign done_sync      = 1'b1;
  assign wait_needed    = 1'b0;
`endif

  // Buffer write port: entry storage only, no reset needed.
  // NOTE: the storage array has no reset; occupancy is tracked by count_q and
  // the pointers, so stale contents are never observed and the array can map
  // onto plain RAM.
  always_ff @(posedge clock_50mhz) begin
    if (push) begin
      mem[wr_ptr_q] <= entry_t'{steps: load.load_steps, word: load.load_word};
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clock_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Next-state and datapath decisions for the issue FSM.
  // NOTE: every output of this block is given its hold value first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    remaining_d = remaining_q;
    raw_d       = raw_q;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (run && !empty) begin
          raw_d       = head.word;
          remaining_d = head.steps;
          phase_d     = PHASE_LOAD;
          state_d     = LOW;
        end
      end

      LOW: begin
        if (phase_q == '0) begin
          phase_d = PHASE_LOAD;
          state_d = HIGH;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end

      HIGH: begin
        if (phase_q == '0) begin
          if (remaining_q != 2'd0) begin
            remaining_d = remaining_q - 2'd1;
            phase_d     = PHASE_LOAD;
            state_d     = LOW;
          end else begin
            pop     = 1'b1;
            state_d = wait_needed ? WAIT_DONE : IDLE;
          end
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end

      WAIT_DONE: begin
        if (done_sync) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register; the button is registered from the next state so it is
  // glitch-free and lines up exactly with the LOW state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      remaining_q <= '0;
      raw_q       <= '0;
      button_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      raw_q       <= raw_d;
      button_q    <= (state_d != LOW);
    end
  end

  assign raw_data_out     = raw_q;
  assign clock_button_out = button_q;
  assign busy             = (state_q != IDLE);

endmodule : step_feeder

// File: tb/tb_step_feeder.sv
// Self-checking bench for step_feeder (DEPTH=16, PULSE_CYCLES=4).
// Stimulus pushes expected entries into a scoreboard queue; an independent
// monitor pops one entry each time busy rises and checks word stability,
// pulse count and pulse widths for that entry.
module tb_step_feeder;

  localparam int DEPTH = 16;
  localparam int PC    = 4;

  typedef struct packed {
    logic [1:0] steps;
    logic [9:0] word;
  } entry_t;

  logic                   clk;
  logic                   reset_n;
  logic                   run;
  logic                   done_in;
  logic [9:0]             raw_data_out;
  logic                   clock_button_out;
  logic                   busy;
  logic                   empty;
  logic                   full;
  logic [$clog2(DEPTH):0] count;

  step_feeder_if bus ();

  step_feeder #(
    .DEPTH        (DEPTH),
    .PULSE_CYCLES (PC)
  ) dut (
    .clock_50mhz      (clk),
    .reset_n          (reset_n),
    .load             (bus),
    .run              (run),
    .done_in          (done_in),
    .raw_data_out     (raw_data_out),
    .clock_button_out (clock_button_out),
    .busy             (busy),
    .empty            (empty),
    .full             (full),
    .count            (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  entry_t exp_q[$];
  bit     gap_check_en = 1'b0;
  bit     had_entry    = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic bit needs_wait(input logic [9:0] w);
`ifdef STEP_FEEDER_DONE_SYNC_EN
    return (w[9:8] == 2'b00) && (w[3:0] != 4'b0000);
`else
    return 1'b0;
`endif
  endfunction

  // Called at a negedge; presents one entry for one edge, returns at the next negedge.
  task automatic push_entry(input logic [1:0] s, input logic [9:0] w, input bit accept);
    bus.load_valid = 1'b1;
    bus.load_steps = s;
    bus.load_word  = w;
    if (accept) exp_q.push_back(entry_t'{steps: s, word: w});
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && empty) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // Monitor: checks each issued entry against the scoreboard head.
  initial begin : monitor
    entry_t cur;
    bit     active;
    bit     prev_cbo;
    int     low_run, high_run, pulses, idle_run;
    active   = 1'b0;
    prev_cbo = 1'b1;
    low_run  = 0;
    high_run = 0;
    pulses   = 0;
    idle_run = 0;
    cur      = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        active    = 1'b0;
        had_entry = 1'b0;
        idle_run  = 0;
      end else if (active && !busy) begin
        check("pulse_count", 32'(pulses), 32'(cur.steps) + 32'd1);
        if (!needs_wait(cur.word)) check("final_high_width", 32'(high_run), 32'(PC));
        check("idle_button_high", 32'(clock_button_out), 32'd1);
        active    = 1'b0;
        had_entry = 1'b1;
        idle_run  = 1;
      end else if (!active && !busy) begin
        idle_run++;
      end else begin
        if (!active) begin
          check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) cur = exp_q.pop_front();
          if (gap_check_en && had_entry) check("idle_gap", 32'(idle_run), 32'd1);
          active   = 1'b1;
          low_run  = 0;
          high_run = 0;
          pulses   = 0;
          prev_cbo = 1'b1;
        end
        check("raw_word", 32'(raw_data_out), 32'(cur.word));
        if (!clock_button_out && prev_cbo) begin
          if (pulses > 0) check("high_width", 32'(high_run), 32'(PC));
          low_run = 0;
        end
        if (clock_button_out && !prev_cbo) begin
          check("low_width", 32'(low_run), 32'(PC));
          pulses++;
          high_run = 0;
        end
        if (clock_button_out) high_run++;
        else                  low_run++;
        prev_cbo = clock_button_out;
      end
    end
  end

  // Watchdog: the run must end on its own well before this.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin : stimulus
    int falls;
    bit prev;
    reset_n        = 1'b0;
    run            = 1'b0;
    done_in        = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_word  = '0;
    bus.load_steps = '0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_raw",   32'(raw_data_out),     32'd0);
    check("rst_cbo",   32'(clock_button_out), 32'd1);
    check("rst_busy",  32'(busy),             32'd0);
    check("rst_empty", 32'(empty),            32'd1);
    check("rst_full",  32'(full),             32'd0);
    check("rst_ready", 32'(bus.load_ready),   32'd1);
    check("rst_count", 32'(count),            32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single entry, one pulse.
    run = 1'b1;
    push_entry(2'd0, 10'h2A5, 1'b1);
    wait_idle(200, "single_done");
    check("single_count", 32'(count), 32'd0);
    check("single_busy",  32'(busy),  32'd0);
    check("single_raw_hold", 32'(raw_data_out), 32'h2A5);

    // Four pulses on one entry.
    push_entry(2'd3, 10'h041, 1'b1);
    wait_idle(300, "multi_done");
    check("multi_raw_hold", 32'(raw_data_out), 32'h041);

    // Fill with Run=0; the 17th entry is dropped.
    run = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      push_entry(2'd0, 10'(10'h300 + i), i < DEPTH);
    end
    check("fill_full",  32'(full),           32'd1);
    check("fill_count", 32'(count),          32'(DEPTH));
    check("fill_ready", 32'(bus.load_ready), 32'd0);
    check("fill_empty", 32'(empty),          32'd0);
    check("fill_busy",  32'(busy),           32'd0);

    // Drain in order; push on the first pop edge while full.
    gap_check_en = 1'b1;
    had_entry    = 1'b0;
    run          = 1'b1;
    repeat (2 * PC) @(negedge clk);
    check("full_at_pop", 32'(full), 32'd1);
    push_entry(2'd0, 10'h3AA, 1'b1);
    check("count_pop_push", 32'(count), 32'(DEPTH));
    wait_idle(800, "drain_done");
    gap_check_en = 1'b0;

    // Reset during the LOW of the second pulse.
    push_entry(2'd3, 10'h155, 1'b1);
    push_entry(2'd0, 10'h0F0, 1'b1);
    falls = 0;
    prev  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (prev && !clock_button_out) falls++;
      prev = clock_button_out;
      if (falls == 2) break;
    end
    check("second_pulse_seen", 32'(falls), 32'd2);
    check("second_pulse_low", 32'(clock_button_out), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_cbo",   32'(clock_button_out), 32'd1);
    check("async_rst_count", 32'(count),            32'd0);
    check("async_rst_busy",  32'(busy),             32'd0);
    check("async_rst_empty", 32'(empty),            32'd1);
    check("async_rst_raw",   32'(raw_data_out),     32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("discarded_busy",  32'(busy),  32'd0);
    check("discarded_empty", 32'(empty), 32'd1);

    // Normal operation after reset.
    push_entry(2'd1, 10'h2C3, 1'b1);
    wait_idle(200, "post_reset_done");

`ifdef STEP_FEEDER_DONE_SYNC_EN
    begin : done_wait_test
      bit started;
      int n;
      done_in = 1'b0;
      repeat (4) @(negedge clk);
      push_entry(2'd0, 10'h012, 1'b1);
      push_entry(2'd0, 10'h2A5, 1'b1);
      started = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (busy) begin
          started = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("wait_started", 32'(started), 32'd1);
      repeat (20) @(negedge clk);
      check("wait_held_busy", 32'(busy), 32'd1);
      check("wait_held_cbo",  32'(clock_button_out), 32'd1);
      done_in = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        n++;
        if (!busy) break;
      end
      check("done_latency_ok", 32'((n >= 2) && (n <= 3)), 32'd1);
      wait_idle(200, "after_done_next_entry");
    end
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_step_feeder
